inst_mem_loader: RTL

Loadable, registered-read instruction memory that replaces the fixed instruction ROM in the processor fetch path. It accepts a program over a valid/ready word stream at run time, with no `$readmem` file dependency, and serves one instruction per fetch with one-cycle latency. A small load FSM blocks fetches while a program is being written. Addresses beyond the populated depth return a halt word.

---
 rtl/inst_mem_loader_if.sv | 30 +++
 rtl/inst_mem_loader.sv | 111 +++++++++++
 2 files changed

// File: rtl/inst_mem_loader_if.sv
// Load-stream and fetch signals between the program source / fetch stage
// (master) and the loadable instruction memory (slave).
interface inst_mem_loader_if #(
  parameter int A = 10,
  parameter int W = 9
);
  logic         LoadStart;
  logic [A-1:0] LoadBase;
  logic [A:0]   LoadLen;
  logic         LoadValid;
  logic [W-1:0] LoadData;
  logic         LoadReady;
  logic         LoadBusy;
  logic         LoadDone;
  logic         LoadErr;
  logic         FetchEn;
  logic [A-1:0] InstAddress;
  logic [W-1:0] InstOut;
  logic         InstValid;

  modport master (
    output LoadStart, LoadBase, LoadLen, LoadValid, LoadData, FetchEn, InstAddress,
    input  LoadReady, LoadBusy, LoadDone, LoadErr, InstOut, InstValid
  );

  modport slave (
    input  LoadStart, LoadBase, LoadLen, LoadValid, LoadData, FetchEn, InstAddress,
    output LoadReady, LoadBusy, LoadDone, LoadErr, InstOut, InstValid
  );
endinterface

// File: rtl/inst_mem_loader.sv
// Run-time loadable instruction memory with one-cycle registered fetch.
// A two-state load FSM writes a word stream and blocks fetches meanwhile.
module inst_mem_loader #(
  parameter int           A         = 10,
  parameter int           W         = 9,
  parameter int           DEPTH     = 2 ** A,
  parameter logic [W-1:0] HALT_WORD = {W{1'b1}}
) (
  input  logic              Clk,
  input  logic              Reset_n,
  inst_mem_loader_if.slave  bus
);

  typedef enum logic {IDLE, LOAD} state_t;

  localparam int           IDX_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [A+1:0] DEPTH_LOAD  = (A+2)'(DEPTH);
  localparam logic [A:0]   DEPTH_FETCH = (A+1)'(DEPTH);

  logic [W-1:0] mem [DEPTH];

  state_t       state;
  logic [A-1:0] ptr;
  logic [A:0]   remaining;
  logic         load_ready;
  logic         load_busy;
  logic         load_done;
  logic         load_err;
  logic         inst_valid;
  logic [W-1:0] inst_out;

  logic         load_fire;
  logic [A+1:0] load_end;

  assign load_fire = (state == LOAD) && bus.LoadValid;
  // Widened so that a session running past the top of memory cannot wrap.
  assign load_end  = {2'b00, bus.LoadBase} + {1'b0, bus.LoadLen};

  always_ff @(posedge Clk) begin
    if (load_fire) begin
      mem[ptr[IDX_W-1:0]] <= bus.LoadData;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= IDLE;
      ptr        <= '0;
      remaining  <= '0;
      load_ready <= 1'b0;
      load_busy  <= 1'b0;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
      inst_valid <= 1'b0;
      inst_out   <= '0;
    end else begin
      load_done  <= 1'b0;
      load_err   <= 1'b0;
      inst_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.FetchEn) begin
            inst_valid <= 1'b1;
            inst_out   <= ({1'b0, bus.InstAddress} < DEPTH_FETCH)
                          ? mem[bus.InstAddress[IDX_W-1:0]] : HALT_WORD;
          end
          if (bus.LoadStart) begin
            if (bus.LoadLen == '0) begin
              load_done <= 1'b1;
            end else if (load_end > DEPTH_LOAD) begin
              load_err <= 1'b1;
            end else begin
              state      <= LOAD;
              ptr        <= bus.LoadBase;
              remaining  <= bus.LoadLen;
              load_ready <= 1'b1;
              load_busy  <= 1'b1;
            end
          end
        end

        LOAD: begin
          if (bus.LoadStart) begin
            load_err <= 1'b1;
          end
          if (bus.LoadValid) begin
            ptr       <= ptr + 1'b1;
            remaining <= remaining - 1'b1;
            if (remaining == (A+1)'(1)) begin
              state      <= IDLE;
              load_ready <= 1'b0;
              load_busy  <= 1'b0;
              load_done  <= 1'b1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.LoadReady = load_ready;
  assign bus.LoadBusy  = load_busy;
  assign bus.LoadDone  = load_done;
  assign bus.LoadErr   = load_err;
  assign bus.InstValid = inst_valid;
  assign bus.InstOut   = inst_out;

endmodule
